// File: rtl/radar_signal_generator.sv
`default_nettype none
// ============================================================================
// Module  : radar_signal_generator
// Brief   : ARP / ACP / TRIG radar timing generator paced by a 1 MHz US_CLK.
// Rev     : 1.0  initial release
// ============================================================================
module radar_signal_generator #(
    parameter int DATA_WIDTH    = 32,
    parameter int ARP_PULSE_US  = 10,
    parameter int TRIG_PULSE_US = 1
) (
    input  logic                  SYS_CLK,
    input  logic                  RST,
    input  logic                  US_CLK,
    input  logic                  EN,
    input  logic [DATA_WIDTH-1:0] CFG_ARP_US,
    input  logic [DATA_WIDTH-1:0] CFG_ACP_CNT,
    input  logic [DATA_WIDTH-1:0] CFG_TRIG_US,
    output logic                  ARP,
    output logic                  ACP,
    output logic                  TRIG,
    output logic                  RUNNING,
    output logic                  CFG_ERR
);

    localparam int AW = DATA_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] c_one        = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_two        = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] c_arp_pulse  = DATA_WIDTH'(ARP_PULSE_US);
    localparam logic [DATA_WIDTH-1:0] c_trig_pulse = DATA_WIDTH'(TRIG_PULSE_US);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_us_meta, r_us_sync, r_us_prev;
    logic w_tick;

    logic [DATA_WIDTH-1:0] r_rc, r_tc, r_sh_arp, r_sh_acp, r_sh_trig;
    logic [AW-1:0]         r_acc;
    logic                  r_arp, r_acp, r_trig, r_cfg_err;

    logic [DATA_WIDTH-1:0] w_rc_nxt, w_tc_nxt;
    logic [AW-1:0]         w_acc_nxt;
    logic                  w_arp_nxt, w_acp_nxt, w_trig_nxt, w_err_nxt, w_load;

    logic [DATA_WIDTH:0]   w_cfg_acp_x2;
    logic                  w_cfg_valid;
    logic [AW-1:0]         w_acc_sum, w_acc_step;
    logic                  w_acp_wrap;
    logic [DATA_WIDTH-1:0] w_tc_step;
    logic                  w_boundary;

    // US_CLK is asynchronous: two synchronizer flops, then an edge flop.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_us_meta <= 1'b0;
            r_us_sync <= 1'b0;
            r_us_prev <= 1'b0;
        end else begin
            r_us_meta <= US_CLK;
            r_us_sync <= r_us_meta;
            r_us_prev <= r_us_sync;
        end
    end

    assign w_tick = r_us_sync & ~r_us_prev;

    assign w_cfg_acp_x2 = {CFG_ACP_CNT, 1'b0};
    assign w_cfg_valid  = (CFG_ARP_US >= c_two) && (CFG_TRIG_US >= c_two) &&
                          (CFG_ACP_CNT != '0) &&
                          (w_cfg_acp_x2 <= {1'b0, CFG_ARP_US}) &&
                          (CFG_ARP_US > c_arp_pulse) && (CFG_TRIG_US > c_trig_pulse);

    // Bresenham-style phase accumulator: 2*ACP_CNT toggles spread over ARP_US ticks.
    assign w_acc_sum  = r_acc + {1'b0, r_sh_acp, 1'b0};
    assign w_acp_wrap = (w_acc_sum >= {2'b00, r_sh_arp});
    assign w_acc_step = w_acp_wrap ? (w_acc_sum - {2'b00, r_sh_arp}) : w_acc_sum;

    assign w_tc_step  = (r_tc >= r_sh_trig - c_one) ? '0 : r_tc + c_one;
    assign w_boundary = (r_rc == r_sh_arp - c_one);

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_tc_nxt    = r_tc;
        w_acc_nxt   = r_acc;
        w_acp_nxt   = r_acp;
        w_arp_nxt   = r_arp;
        w_trig_nxt  = r_trig;
        w_err_nxt   = r_cfg_err;
        w_load      = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_rc_nxt  = '0;
                    w_tc_nxt  = '0;
                    w_acc_nxt = '0;
                    w_acp_nxt = 1'b0;
                    w_err_nxt = EN & ~w_cfg_valid;
                    if (EN && w_cfg_valid) begin
                        w_state_nxt = S_RUN;
                        w_load      = 1'b1;
                    end
                end
                S_RUN: begin
                    w_tc_nxt  = w_tc_step;
                    w_err_nxt = 1'b0;
                    if (w_boundary) begin
                        w_rc_nxt  = '0;
                        w_acc_nxt = '0;
                        w_acp_nxt = 1'b0;
                        if (EN && w_cfg_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_tc_nxt    = '0;
                            w_err_nxt   = EN & ~w_cfg_valid;
                        end
                    end else begin
                        w_rc_nxt  = r_rc + c_one;
                        w_acc_nxt = w_acc_step;
                        w_acp_nxt = r_acp ^ w_acp_wrap;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            w_arp_nxt  = (w_state_nxt == S_RUN) && (w_rc_nxt < c_arp_pulse);
            w_trig_nxt = (w_state_nxt == S_RUN) && (w_tc_nxt < c_trig_pulse);
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_rc      <= '0;
            r_tc      <= '0;
            r_acc     <= '0;
            r_arp     <= 1'b0;
            r_acp     <= 1'b0;
            r_trig    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_sh_arp  <= '0;
            r_sh_acp  <= '0;
            r_sh_trig <= '0;
        end else begin
            r_rc      <= w_rc_nxt;
            r_tc      <= w_tc_nxt;
            r_acc     <= w_acc_nxt;
            r_arp     <= w_arp_nxt;
            r_acp     <= w_acp_nxt;
            r_trig    <= w_trig_nxt;
            r_cfg_err <= w_err_nxt;
            if (w_load) begin
                r_sh_arp  <= CFG_ARP_US;
                r_sh_acp  <= CFG_ACP_CNT;
                r_sh_trig <= CFG_TRIG_US;
            end
        end
    end

    assign ARP     = r_arp;
    assign ACP     = r_acp;
    assign TRIG    = r_trig;
    assign RUNNING = (r_state == S_RUN);
    assign CFG_ERR = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_radar_signal_generator.sv
`default_nettype none
// ============================================================================
// Module  : tb_radar_signal_generator
// Brief   : Scoreboard bench for radar_signal_generator (scaled-down periods).
// Rev     : 1.0  initial release
// ============================================================================
module tb_radar_signal_generator;

    localparam int DW      = 32;
    localparam int ARP_PW  = 10;
    localparam int TRIG_PW = 1;

    logic          SYS_CLK = 1'b0;
    logic          RST     = 1'b1;
    logic          US_CLK  = 1'b0;
    logic          EN      = 1'b0;
    logic [DW-1:0] CFG_ARP_US  = '0;
    logic [DW-1:0] CFG_ACP_CNT = '0;
    logic [DW-1:0] CFG_TRIG_US = '0;
    logic          ARP, ACP, TRIG, RUNNING, CFG_ERR;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] exp_q[$];

    bit     m_run = 1'b0;
    bit     m_err = 1'b0;
    longint m_k = 0, m_tc = 0, m_arp = 0, m_acp = 0, m_trig = 0;
    bit     rev_done = 1'b0;
    longint rev_acp = 0;
    int     acp_rises = 0;
    bit     acp_prev = 1'b0;

    radar_signal_generator #(
        .DATA_WIDTH   (DW),
        .ARP_PULSE_US (ARP_PW),
        .TRIG_PULSE_US(TRIG_PW)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .US_CLK     (US_CLK),
        .EN         (EN),
        .CFG_ARP_US (CFG_ARP_US),
        .CFG_ACP_CNT(CFG_ACP_CNT),
        .CFG_TRIG_US(CFG_TRIG_US),
        .ARP        (ARP),
        .ACP        (ACP),
        .TRIG       (TRIG),
        .RUNNING    (RUNNING),
        .CFG_ERR    (CFG_ERR)
    );

    // SYS_CLK rises on odd times, US_CLK edges and sampling on even times.
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cfg_ok(input longint a, input longint n, input longint t);
        return (a >= 2) && (t >= 2) && (n >= 1) && (2 * n <= a) &&
               (a > ARP_PW) && (t > TRIG_PW);
    endfunction

    task automatic latch_cfg();
        m_arp  = longint'(CFG_ARP_US);
        m_acp  = longint'(CFG_ACP_CNT);
        m_trig = longint'(CFG_TRIG_US);
    endtask

    task automatic model_tick();
        bit ok;
        ok = cfg_ok(longint'(CFG_ARP_US), longint'(CFG_ACP_CNT), longint'(CFG_TRIG_US));
        rev_done = 1'b0;
        if (!m_run) begin
            if (EN && ok) begin
                m_run = 1'b1; m_err = 1'b0; m_k = 0; m_tc = 0;
                latch_cfg();
            end else begin
                m_err = EN && !ok;
            end
        end else begin
            m_tc = (m_tc >= m_trig - 1) ? 0 : m_tc + 1;
            if (m_k == m_arp - 1) begin
                rev_done = 1'b1;
                rev_acp  = m_acp;
                if (EN && ok) begin
                    m_k = 0;
                    latch_cfg();
                end else begin
                    m_run = 1'b0;
                    m_err = EN && !ok;
                end
            end else begin
                m_k++;
            end
        end
    endtask

    // ACP level at revolution index k is the parity of floor(k*2N/ARP).
    function automatic logic [4:0] model_out();
        logic a, c, t;
        if (!m_run) return {4'b0000, m_err};
        a = (m_k < ARP_PW);
        c = ((((m_k * 2 * m_acp) / m_arp) % 2) == 1);
        t = (m_tc < TRIG_PW);
        return {1'b1, a, c, t, 1'b0};
    endfunction

    task automatic us_cycle(input bit lat);
        time        t0;
        logic [4:0] e;
        t0 = $time;
        US_CLK = 1'b1;
        model_tick();
        exp_q.push_back(model_out());
        if (lat) begin
            @(posedge SYS_CLK); @(posedge SYS_CLK); #1;
            check("lat_pre", 32'(ARP), 32'd0);
            @(posedge SYS_CLK); #1;
            check("lat_arp", 32'(ARP), 32'd1);
        end
        #(t0 + 42 - $time);
        e = exp_q.pop_front();
        check("tick", 32'({RUNNING, ARP, ACP, TRIG, CFG_ERR}), 32'(e));
        if (ACP && !acp_prev) acp_rises++;
        acp_prev = ACP;
        if (rev_done) check("acp_rises", 32'(acp_rises), 32'(rev_acp));
        if (!m_run || m_k == 0) acp_rises = 0;
        #2;
        US_CLK = 1'b0;
        #42;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) us_cycle(1'b0);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #2;
        check("rst_out", 32'({RUNNING, ARP, ACP, TRIG, CFG_ERR}), 32'd0);
        #20;
        RST = 1'b0;
        #20;
        m_run = 1'b0; m_err = 1'b0;
        acp_rises = 0; acp_prev = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #12;
        check("rst_init", 32'({RUNNING, ARP, ACP, TRIG, CFG_ERR}), 32'd0);
        RST = 1'b0;
        #2;

        CFG_ARP_US = 40; CFG_ACP_CNT = 3; CFG_TRIG_US = 11;
        run(3);
        EN = 1'b1;
        us_cycle(1'b1);
        run(79);
        run(21);

        // Mid-revolution change; new TRIG_US is below tc after the boundary.
        CFG_TRIG_US = 3; CFG_ACP_CNT = 20;
        run(60);

        run(15);
        EN = 1'b0;
        run(29);

        CFG_ACP_CNT = 25;
        EN = 1'b1;
        run(4);

        CFG_ACP_CNT = 4; CFG_ARP_US = 30; CFG_TRIG_US = 7;
        run(13);
        pulse_reset();
        us_cycle(1'b1);
        run(30);

        run(5);
        CFG_TRIG_US = 1;
        run(25);
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
